slot_allocator: RTL and testbench



---
 rtl/slot_allocator.sv | 145 ++++++++++++++
 tb/tb_slot_allocator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/slot_allocator.sv
// slot_allocator: tracks occupancy of NUM_SLOTS buffer slots.
// Each request is granted the lowest-numbered free slot. The downstream
// consumer releases slots by index, and a flush clears every slot at once.
// The busy vector and the free count are registered together, so the
// status outputs always describe the same occupancy state.
module slot_allocator #(
    parameter  int NUM_SLOTS   = 8,
    localparam int INDEX_WIDTH = $clog2(NUM_SLOTS),
    localparam int COUNT_WIDTH = INDEX_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_req_in,
    output logic                   alloc_gnt_out,
    output logic [INDEX_WIDTH-1:0] alloc_index_out,
    input  logic                   release_valid_in,
    input  logic [INDEX_WIDTH-1:0] release_index_in,
    output logic                   release_err_out,
    input  logic                   flush_in,
    output logic [NUM_SLOTS-1:0]   busy_vec_out,
    output logic [COUNT_WIDTH-1:0] free_count_out,
    output logic                   full_out,
    output logic                   empty_out
);

    // Registered state and its next-state values
    logic [NUM_SLOTS-1:0]   busy_q, busy_d;
    logic                   gnt_q, gnt_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] free_count_q, free_count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;

    // Combinational decisions for the current cycle
    logic [INDEX_WIDTH-1:0] sel_idx;
    logic                   any_free;
    logic                   rel_hit;
    logic                   alloc_fire;
    logic                   rel_fire;
    logic                   rel_err;

    // Lowest-set-bit selection on the inverted busy vector; scanning from
    // the top down lets the lowest free slot overwrite any higher one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        sel_idx  = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                sel_idx  = INDEX_WIDTH'(i);
                any_free = 1'b1;
            end
        end
    end

    // A release is legal only for an in-range slot that is currently busy;
    // indices >= NUM_SLOTS never match any slot and so read as not busy.
    always_comb begin
        rel_hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (release_index_in == INDEX_WIDTH'(i)) begin
                rel_hit = busy_q[i];
            end
        end
    end

    // Per-cycle actions; flush overrides both alloc and release
    always_comb begin
        alloc_fire = alloc_req_in & any_free & ~flush_in;
        rel_fire   = release_valid_in & rel_hit & ~flush_in;
        rel_err    = release_valid_in & ~rel_hit & ~flush_in;
    end

    // Next-state occupancy. Selection used the pre-release busy_q, so a
    // slot being released this cycle can never also be granted this cycle.
    always_comb begin
        busy_d = busy_q;
        if (flush_in) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alloc_fire && (sel_idx == INDEX_WIDTH'(i))) begin
                    busy_d[i] = 1'b1;
                end
                if (rel_fire && (release_index_in == INDEX_WIDTH'(i))) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    // Free count tracks next-state busy: -1 per grant, +1 per release
    always_comb begin
        if (flush_in) begin
            free_count_d = COUNT_WIDTH'(NUM_SLOTS);
        end else begin
            free_count_d = free_count_q
                         - COUNT_WIDTH'(alloc_fire)
                         + COUNT_WIDTH'(rel_fire);
        end
        full_d  = (free_count_d == '0);
        empty_d = (free_count_d == COUNT_WIDTH'(NUM_SLOTS));
    end

    // Grant and error pulses; the granted index holds between grants
    always_comb begin
        gnt_d   = alloc_fire;
        index_d = alloc_fire ? sel_idx : index_q;
        err_d   = rel_err;
    end

    // State register with asynchronous reset to the all-free state
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the values from before this edge.
        if (!rst_n) begin
            busy_q       <= '0;
            gnt_q        <= 1'b0;
            index_q      <= '0;
            err_q        <= 1'b0;
            free_count_q <= COUNT_WIDTH'(NUM_SLOTS);
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            busy_q       <= busy_d;
            gnt_q        <= gnt_d;
            index_q      <= index_d;
            err_q        <= err_d;
            free_count_q <= free_count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
        end
    end

    assign alloc_gnt_out   = gnt_q;
    assign alloc_index_out = index_q;
    assign release_err_out = err_q;
    assign busy_vec_out    = busy_q;
    assign free_count_out  = free_count_q;
    assign full_out        = full_q;
    assign empty_out       = empty_q;

endmodule

// File: tb/tb_slot_allocator.sv
// Bench for slot_allocator: one 8-slot and one 6-slot instance share the
// same stimulus and are each checked against a behavioural model.
module tb_slot_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       rv;
    logic [2:0] ri;
    logic       fl;

    logic       gnt_a, err_a, full_a, empty_a;
    logic [2:0] idx_a;
    logic [7:0] busy_a;
    logic [3:0] cnt_a;

    logic       gnt_b, err_b, full_b, empty_b;
    logic [2:0] idx_b;
    logic [5:0] busy_b;
    logic [3:0] cnt_b;

    always #5 clk = ~clk;

    slot_allocator #(.NUM_SLOTS(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_in(req), .alloc_gnt_out(gnt_a), .alloc_index_out(idx_a),
        .release_valid_in(rv), .release_index_in(ri), .release_err_out(err_a),
        .flush_in(fl), .busy_vec_out(busy_a), .free_count_out(cnt_a),
        .full_out(full_a), .empty_out(empty_a)
    );

    slot_allocator #(.NUM_SLOTS(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_in(req), .alloc_gnt_out(gnt_b), .alloc_index_out(idx_b),
        .release_valid_in(rv), .release_index_in(ri), .release_err_out(err_b),
        .flush_in(fl), .busy_vec_out(busy_b), .free_count_out(cnt_b),
        .full_out(full_b), .empty_out(empty_b)
    );

    typedef struct {
        logic [7:0] busy;
        logic       gnt;
        logic [2:0] idx;
        logic       err;
    } model_t;

    model_t ma, mb;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int free_slots(input model_t m, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (!m.busy[i]) c++;
        return c;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.busy = '0;
        r.gnt  = 1'b0;
        r.idx  = '0;
        r.err  = 1'b0;
        return r;
    endfunction

    // One clock edge of the allocator rules, applied to occupancy n slots wide
    function automatic model_t model_step(input model_t m, input int n, input logic a_req,
                                          input logic r_v, input logic [2:0] r_i, input logic f);
        model_t r = m;
        int lowest = -1;
        r.gnt = 1'b0;
        r.err = 1'b0;
        if (f) begin
            r.busy = '0;
        end else begin
            for (int i = 0; i < n; i++) if (!m.busy[i] && lowest < 0) lowest = i;
            if (a_req && lowest >= 0) begin
                r.busy[lowest] = 1'b1;
                r.gnt          = 1'b1;
                r.idx          = lowest[2:0];
            end
            if (r_v) begin
                if (int'(r_i) < n && m.busy[r_i]) r.busy[r_i] = 1'b0;
                else r.err = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic compare(input string who, input model_t m, input int n,
                           input logic g, input logic [2:0] x, input logic e,
                           input logic [7:0] b, input logic [3:0] c,
                           input logic fu, input logic em);
        int fc = free_slots(m, n);
        check({who, "_gnt"},   32'(g),  32'(m.gnt));
        check({who, "_idx"},   32'(x),  32'(m.idx));
        check({who, "_err"},   32'(e),  32'(m.err));
        check({who, "_busy"},  32'(b),  32'(m.busy));
        check({who, "_count"}, 32'(c),  32'(fc));
        check({who, "_full"},  32'(fu), 32'(fc == 0));
        check({who, "_empty"}, 32'(em), 32'(fc == n));
    endtask

    task automatic compare_all();
        compare("a", ma, 8, gnt_a, idx_a, err_a, busy_a, cnt_a, full_a, empty_a);
        compare("b", mb, 6, gnt_b, idx_b, err_b, {2'b00, busy_b}, cnt_b, full_b, empty_b);
    endtask

    // Drive one cycle of inputs, let the edge happen, check both instances
    task automatic cycle(input logic a_req, input logic r_v, input logic [2:0] r_i, input logic f);
        req = a_req;
        rv  = r_v;
        ri  = r_i;
        fl  = f;
        @(posedge clk);
        #1;
        ma = model_step(ma, 8, a_req, r_v, r_i, f);
        mb = model_step(mb, 6, a_req, r_v, r_i, f);
        compare_all();
    endtask

    // Assert reset between clock edges and check outputs clear immediately
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 1'b0;
        rv    = 1'b0;
        ri    = '0;
        fl    = 1'b0;
        ma    = model_reset();
        mb    = model_reset();
        do_reset();

        // Fill from empty: grants 0..7 on consecutive cycles, ninth refused
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 3'd0, 1'b0);
        check("fill_full",  32'(full_a), 32'd1);
        check("fill_count", 32'(cnt_a),  32'd0);
        check("fill_busy",  32'(busy_a), 32'hFF);

        // Release 5 while full and requesting: grant comes one cycle later
        cycle(1'b1, 1'b1, 3'd5, 1'b0);
        check("relfull_nogrant", 32'(gnt_a),  32'd0);
        check("relfull_busy",    32'(busy_a), 32'hDF);
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        check("relfull_gnt", 32'(gnt_a),  32'd1);
        check("relfull_idx", 32'(idx_a),  32'd5);
        check("relfull_full", 32'(full_a), 32'd1);

        // From 8'h0F: free slot 2 must be granted before slot 4
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 3'd0, 1'b0);
        check("lowest_setup", 32'(busy_a), 32'h0F);
        cycle(1'b0, 1'b1, 3'd2, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        check("lowest_first", 32'(idx_a), 32'd2);
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        check("lowest_next", 32'(idx_a), 32'd4);

        // Illegal releases: free slot 6, then index 7 on the 6-slot instance
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        cycle(1'b0, 1'b1, 3'd6, 1'b0);
        check("relfree_err",   32'(err_a),  32'd1);
        check("relfree_busy",  32'(busy_a), 32'h01);
        check("relfree_count", 32'(cnt_a),  32'd7);
        cycle(1'b0, 1'b1, 3'd7, 1'b0);
        check("relrange_err",   32'(err_b),  32'd1);
        check("relrange_busy",  32'(busy_b), 32'h01);
        check("relrange_count", 32'(cnt_b),  32'd5);
        cycle(1'b0, 1'b0, 3'd0, 1'b0);
        check("err_pulse_end", 32'(err_a), 32'd0);

        // Flush overrides a simultaneous grant and a legal release
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 1'b1, 3'd0, 1'b1);
        check("flush_gnt",   32'(gnt_a),   32'd0);
        check("flush_err",   32'(err_a),   32'd0);
        check("flush_busy",  32'(busy_a),  32'd0);
        check("flush_empty", 32'(empty_a), 32'd1);
        check("flush_count", 32'(cnt_a),   32'd8);

        // Reset mid-burst, then the first grant is slot 0 again
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'd0, 1'b0);
        do_reset();
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        check("postreset_gnt", 32'(gnt_a), 32'd1);
        check("postreset_idx", 32'(idx_a), 32'd0);

        // Randomized traffic with occasional flushes and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 65,
                      $urandom_range(0, 99) < 45,
                      3'($urandom_range(0, 7)),
                      $urandom_range(0, 99) < 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
